// File: rtl/uart_pkg.sv
// Shared UART definitions: line timing, header tag and arbiter FSM states.
package uart_pkg;

    localparam int unsigned CLK_HZ  = 50_000_000;
    localparam int unsigned BAUD    = 9600;
    localparam int unsigned BIT_CYC = 5208;
    localparam logic [3:0]  HDR_TAG = 4'hA;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_HDR_START,
        ST_HDR_WAIT,
        ST_DAT_START,
        ST_DAT_WAIT,
        ST_ACK
    } arb_state_t;

    // Source-ID header byte: tag in the high nibble, 3-bit id wrapped mod 8.
    function automatic logic [7:0] hdr_byte(input int unsigned idx, input int unsigned base);
        logic [2:0] id;
        id = 3'((idx + base) % 8);
        return {HDR_TAG, 1'b0, id};
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr.
module rr_pick #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [IW-1:0] pos;

    // Scan ptr, ptr+1, ... mod N and keep the first requester found.
    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        pos    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = IW'((32'(ptr) + k) % N);
            if (!valid && req[pos]) begin
                valid       = 1'b1;
                onehot[pos] = 1'b1;
                idx         = pos;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART shifter among N_REQ byte requesters.
module uart_tx_arbiter import uart_pkg::*; #(
    parameter int unsigned N_REQ   = 4,
    parameter bit          ADD_ID  = 1'b1,
    parameter int unsigned ID_BASE = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   ack,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    input  logic               tx_busy,
    input  logic               tx_done,
    output logic [2:0]         grant_id,
    output logic               active
);

    localparam int unsigned IW = $clog2(N_REQ);

    arb_state_t       state;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    gnt_idx;
    logic [N_REQ-1:0] gnt_oh;
    logic [7:0]       data_q;

    logic [N_REQ-1:0] pick_oh;
    logic [IW-1:0]    pick_idx;
    logic             pick_valid;

    rr_pick #(.N(N_REQ)) u_pick (
        .req    (req),
        .ptr    (rr_ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    // Transaction sequencer: grant, optional header frame, data frame, ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            gnt_idx  <= '0;
            gnt_oh   <= '0;
            data_q   <= '0;
            ack      <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            grant_id <= '0;
            active   <= 1'b0;
        end else begin
            ack      <= '0;
            tx_start <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (|req) state <= ST_GRANT;
                end
                ST_GRANT: begin
                    // A request withdrawn between IDLE and GRANT leaves nothing to serve.
                    if (pick_valid) begin
                        gnt_idx  <= pick_idx;
                        gnt_oh   <= pick_oh;
                        data_q   <= req_data[8*pick_idx +: 8];
                        grant_id <= 3'(pick_idx);
                        active   <= 1'b1;
                        state    <= ADD_ID ? ST_HDR_START : ST_DAT_START;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_HDR_START: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= hdr_byte(32'(gnt_idx), ID_BASE);
                        state    <= ST_HDR_WAIT;
                    end
                end
                ST_HDR_WAIT: begin
                    if (tx_done) state <= ST_DAT_START;
                end
                ST_DAT_START: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= data_q;
                        state    <= ST_DAT_WAIT;
                    end
                end
                ST_DAT_WAIT: begin
                    if (tx_done) begin
                        ack   <= gnt_oh;
                        state <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    active <= 1'b0;
                    rr_ptr <= (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
